// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU: data width and ALUSel codes.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;

   localparam logic [SEL_W-1:0] ALU_ADD   = 4'b0000;
   localparam logic [SEL_W-1:0] ALU_SUB   = 4'b0001;
   localparam logic [SEL_W-1:0] ALU_SLL   = 4'b0010;
   localparam logic [SEL_W-1:0] ALU_SLT   = 4'b0011;
   localparam logic [SEL_W-1:0] ALU_SLTU  = 4'b0100;
   localparam logic [SEL_W-1:0] ALU_XOR   = 4'b0101;
   localparam logic [SEL_W-1:0] ALU_SRL   = 4'b0110;
   localparam logic [SEL_W-1:0] ALU_SRA   = 4'b0111;
   localparam logic [SEL_W-1:0] ALU_OR    = 4'b1000;
   localparam logic [SEL_W-1:0] ALU_AND   = 4'b1001;
   localparam logic [SEL_W-1:0] ALU_PASSB = 4'b1110;
   localparam logic [SEL_W-1:0] ALU_PASSA = 4'b1111;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: one of twelve operations selected by i_sel.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH_DATA_LENGTH   = DATA_W,
   parameter int WIDTH_ALUSEL_LENGTH = SEL_W
) (
   input  logic [WIDTH_DATA_LENGTH-1:0]   i_a,
   input  logic [WIDTH_DATA_LENGTH-1:0]   i_b,
   input  logic [WIDTH_ALUSEL_LENGTH-1:0] i_sel,
   output logic [WIDTH_DATA_LENGTH-1:0]   o_result
);

   logic [4:0] w_sh;
   logic       w_lt_signed;
   logic       w_lt_unsigned;

   // Only the low five bits of B act as the shift amount; the rest are ignored.
   assign w_sh          = i_b[4:0];
   assign w_lt_signed   = $signed(i_a) < $signed(i_b);
   assign w_lt_unsigned = i_a < i_b;

   always_comb begin
      o_result = '0;
      case (i_sel)
         ALU_ADD:   o_result = i_a + i_b;
         ALU_SUB:   o_result = i_a - i_b;
         ALU_SLL:   o_result = i_a << w_sh;
         ALU_SLT:   o_result = {{(WIDTH_DATA_LENGTH-1){1'b0}}, w_lt_signed};
         ALU_SLTU:  o_result = {{(WIDTH_DATA_LENGTH-1){1'b0}}, w_lt_unsigned};
         ALU_XOR:   o_result = i_a ^ i_b;
         ALU_SRL:   o_result = i_a >> w_sh;
         ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_sh);
         ALU_OR:    o_result = i_a | i_b;
         ALU_AND:   o_result = i_a & i_b;
         ALU_PASSB: o_result = i_b;
         ALU_PASSA: o_result = i_a;
         default:   o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered RV32I ALU: result, zero flag and valid strobe appear one clock after the operands.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH_DATA_LENGTH   = DATA_W,
   parameter int WIDTH_ALUSEL_LENGTH = SEL_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [WIDTH_DATA_LENGTH-1:0]   DataA,
   input  logic [WIDTH_DATA_LENGTH-1:0]   DataB,
   input  logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
   input  logic                           in_valid,
   output logic [WIDTH_DATA_LENGTH-1:0]   DataOut,
   output logic                           out_valid,
   output logic                           Zero
);

   logic [WIDTH_DATA_LENGTH-1:0] w_result;
   logic                         w_zero;
   logic [WIDTH_DATA_LENGTH-1:0] r_data_out;
   logic                         r_zero;
   logic                         r_out_valid;

   alu_core #(
      .WIDTH_DATA_LENGTH   (WIDTH_DATA_LENGTH),
      .WIDTH_ALUSEL_LENGTH (WIDTH_ALUSEL_LENGTH)
   ) u_core (
      .i_a      (DataA),
      .i_b      (DataB),
      .i_sel    (ALUSel),
      .o_result (w_result)
   );

   assign w_zero = (w_result == '0);

   // Result and flag hold while idle; only the valid strobe follows in_valid every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out  <= '0;
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_data_out <= w_result;
            r_zero     <= w_zero;
         end
      end
   end

   assign DataOut   = r_data_out;
   assign Zero      = r_zero;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu.sv
// Directed table-driven bench for the registered ALU plus reset/hold sequences.
module tb_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] DataA = '0;
   logic [31:0] DataB = '0;
   logic [3:0]  ALUSel = '0;
   logic        in_valid = 1'b0;
   logic [31:0] DataOut;
   logic        out_valid;
   logic        Zero;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        exp_zero;
   } vec_t;

   vec_t        vecs[$];
   logic [32:0] exp_q[$];

   alu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .DataA     (DataA),
      .DataB     (DataB),
      .ALUSel    (ALUSel),
      .in_valid  (in_valid),
      .DataOut   (DataOut),
      .out_valid (out_valid),
      .Zero      (Zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [3:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input logic z);
      vec_t v;
      v.name = name; v.sel = sel; v.a = a; v.b = b; v.exp = exp; v.exp_zero = z;
      return v;
   endfunction

   task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic vld);
      @(negedge clk);
      ALUSel = sel; DataA = a; DataB = b; in_valid = vld;
   endtask

   initial begin
      logic [32:0] e;
      vec_t        v;

      vecs.push_back(mk("add_pos",     ALU_ADD,   32'd100,        32'd456,        32'd556,        1'b0));
      vecs.push_back(mk("add_neg",     ALU_ADD,   32'hFFFFFF9C,   32'hFFFFFB2D,   32'hFFFFFAC9,   1'b0));
      vecs.push_back(mk("add_wrap0",   ALU_ADD,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b1));
      vecs.push_back(mk("sub_pos",     ALU_SUB,   32'd5000,       32'd1234,       32'd3766,       1'b0));
      vecs.push_back(mk("sub_neg_res", ALU_SUB,   32'd1234,       32'd2345,       32'hFFFFFBA9,   1'b0));
      vecs.push_back(mk("sub_nn",      ALU_SUB,   32'hFFFFF060,   32'hFFFFF830,   32'hFFFFF830,   1'b0));
      vecs.push_back(mk("sub_np",      ALU_SUB,   32'hFFFFF060,   32'd1245,       32'hFFFFEB83,   1'b0));
      vecs.push_back(mk("sub_eq0",     ALU_SUB,   32'h12345678,   32'h12345678,   32'd0,          1'b1));
      vecs.push_back(mk("sll5",        ALU_SLL,   32'hF0F0A4A4,   32'd5,          32'h1E149480,   1'b0));
      vecs.push_back(mk("srl5",        ALU_SRL,   32'hF0F0A4A4,   32'd5,          32'h07878525,   1'b0));
      vecs.push_back(mk("sra5",        ALU_SRA,   32'hF0F0A4A4,   32'd5,          32'hFF878525,   1'b0));
      vecs.push_back(mk("sra5_hi_b",   ALU_SRA,   32'hF0F0A4A4,   32'hFFFFFFE5,   32'hFF878525,   1'b0));
      vecs.push_back(mk("sll31",       ALU_SLL,   32'h00000003,   32'd31,         32'h80000000,   1'b0));
      vecs.push_back(mk("srl31",       ALU_SRL,   32'h80000000,   32'd31,         32'h00000001,   1'b0));
      vecs.push_back(mk("sra31",       ALU_SRA,   32'h80000000,   32'd31,         32'hFFFFFFFF,   1'b0));
      vecs.push_back(mk("sra0",        ALU_SRA,   32'h80000001,   32'd32,         32'h80000001,   1'b0));
      vecs.push_back(mk("slt_lt",      ALU_SLT,   32'd100,        32'd5000,       32'd1,          1'b0));
      vecs.push_back(mk("slt_neg_gt",  ALU_SLT,   32'hFFFFEC78,   32'hFFFFEC77,   32'd0,          1'b1));
      vecs.push_back(mk("slt_eq",      ALU_SLT,   32'hFFFFFB2E,   32'hFFFFFB2E,   32'd0,          1'b1));
      vecs.push_back(mk("slt_sign",    ALU_SLT,   32'h80000000,   32'd1,          32'd1,          1'b0));
      vecs.push_back(mk("sltu_lt",     ALU_SLTU,  32'd1234,       32'd4321,       32'd1,          1'b0));
      vecs.push_back(mk("sltu_neg",    ALU_SLTU,  32'hFFFFFB2E,   32'hFFFFFC18,   32'd1,          1'b0));
      vecs.push_back(mk("sltu_sign",   ALU_SLTU,  32'h80000000,   32'd1,          32'd0,          1'b1));
      vecs.push_back(mk("xor",         ALU_XOR,   32'h1234F0F0,   32'hFF001222,   32'hED34E2D2,   1'b0));
      vecs.push_back(mk("or",          ALU_OR,    32'h1234F0F0,   32'hFF001222,   32'hFF34F2F2,   1'b0));
      vecs.push_back(mk("and",         ALU_AND,   32'h1234F0F0,   32'hFF001222,   32'h12001020,   1'b0));
      vecs.push_back(mk("rsv_1010",    4'b1010,   32'h1234F0F0,   32'hFF001222,   32'd0,          1'b1));
      vecs.push_back(mk("rsv_1101",    4'b1101,   32'h1234F0F0,   32'hFF001222,   32'd0,          1'b1));
      vecs.push_back(mk("passb",       ALU_PASSB, 32'h1234F0F0,   32'hFF001222,   32'hFF001222,   1'b0));
      vecs.push_back(mk("passa",       ALU_PASSA, 32'h1234F0F0,   32'hFF001222,   32'h1234F0F0,   1'b0));

      // Reset state, applied through a clock edge with rst_n held low.
      repeat (2) @(posedge clk);
      #1;
      check("rst_data",  DataOut,          32'd0);
      check("rst_zero",  {31'd0, Zero},      32'd1);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back table vectors, one operation per cycle.
      foreach (vecs[i]) begin
         v = vecs[i];
         drive(v.sel, v.a, v.b, 1'b1);
         exp_q.push_back({v.exp_zero, v.exp});
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check({v.name, "_data"},  DataOut,            e[31:0]);
         check({v.name, "_zero"},  {31'd0, Zero},      {31'd0, e[32]});
         check({v.name, "_valid"}, {31'd0, out_valid}, 32'd1);
      end

      // Idle cycle: result and flag hold, valid drops.
      drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      check("hold_data",  DataOut,            32'h1234F0F0);
      check("hold_zero",  {31'd0, Zero},      32'd0);
      check("hold_valid", {31'd0, out_valid}, 32'd0);

      // Mid-stream asynchronous reset, observed before any further edge.
      drive(ALU_ADD, 32'd1, 32'd2, 1'b1);
      @(posedge clk);
      #1;
      check("pre_rst_data",  DataOut,            32'd3);
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_data",  DataOut,            32'd0);
      check("async_rst_zero",  {31'd0, Zero},      32'd1);
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);

      // Reset held across an edge with in_valid high must block the capture.
      @(posedge clk);
      #1;
      check("rst_block_data",  DataOut,            32'd0);
      check("rst_block_valid", {31'd0, out_valid}, 32'd0);

      // First capture after release.
      drive(ALU_SUB, 32'd10, 32'd3, 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_data",  DataOut,            32'd7);
      check("post_rst_zero",  {31'd0, Zero},      32'd0);
      check("post_rst_valid", {31'd0, out_valid}, 32'd1);

      drive(ALU_ADD, 32'd0, 32'd0, 1'b0);
      @(posedge clk);
      #1;
      check("final_idle_valid", {31'd0, out_valid}, 32'd0);
      check("final_idle_data",  DataOut,            32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/alu.md
# alu

32-bit integer ALU for the RV32I datapath, placed in the execute stage between the operand muxes and the writeback/branch logic. It evaluates one of twelve operations, selected by a 4-bit `ALUSel` code, on two operands `DataA` and `DataB`. The result is registered: it appears one clock after the operands are presented, together with a valid strobe and a zero flag.

## Interface
- `WIDTH_DATA_LENGTH`, default 32: operand and result width. Shift logic requires a value of 32.
- `WIDTH_ALUSEL_LENGTH`, default 4: width of the operation select.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `DataA`  input  32: operand A (rs1 or PC).
- `DataB`  input  32: operand B (rs2 or immediate).
- `ALUSel`  input  4: operation select.
- `in_valid`  input  1: operands and select are valid this cycle.
- `DataOut`  output  32: registered result.
- `out_valid`  output  1: `DataOut` is valid; this is `in_valid` delayed by one cycle.
- `Zero`  output  1: registered flag, equal to (result == 0).

## Operation
Operation codes. Shift amount `sh` is `DataB[4:0]`; upper bits of `DataB` are ignored for shifts.
- 0000 ADD: A + B, modulo 2^32, no carry or overflow output.
- 0001 SUB: A − B, modulo 2^32.
- 0010 SLL: A << sh, zero fill.
- 0011 SLT: 1 if $signed(A) < $signed(B), else 0; zero-extended to 32 bits.
- 0100 SLTU: 1 if A < B unsigned, else 0.
- 0101 XOR: A ^ B.
- 0110 SRL: A >> sh, zero fill.
- 0111 SRA: A >> sh, sign fill from A[31].
- 1000 OR: A | B.
- 1001 AND: A & B.
- 1110 PASSB: result = B (LUI path).
- 1111 PASSA: result = A.
- 1010–1101 reserved: result = 0, `Zero` = 1. The select must never produce X.

Equal operands give SLT = 0 and SLTU = 0.

## Timing
- Combinational result computed from the current inputs; captured on the rising `clk` edge when `in_valid` = 1.
- Latency 1 cycle, throughput 1 operation per cycle; back-to-back operations are allowed.
- When `in_valid` = 0: `DataOut` and `Zero` hold their previous values; `out_valid` drops to 0 on the next edge.
- Reset values: `DataOut` = 0, `Zero` = 1, `out_valid` = 0.
  - Reset is asynchronous on `rst_n` falling and overrides any in-flight capture.
  - The first capture happens on the first rising edge with `rst_n` = 1 and `in_valid` = 1.
- No handshake back-pressure; the consumer must accept every `out_valid` pulse.

## Structure
- Shared package `alu_pkg` holds:
  - localparams for all twelve `ALUSel` codes (ALU_ADD … ALU_PASSA);
  - the data width constant.
  The decoder and control unit import the same package.
- One natural sub-module, `alu_core`: the purely combinational datapath (the case on `ALUSel`).
- The `alu` top adds the output register, valid pipeline and zero flag.

## Test plan
In every scenario, drive `in_valid` = 1 and check outputs one cycle later.
- ADD:
  - 100 + 456 → 556, `Zero` = 0.
  - −100 + −1235 → 0xFFFFFAC9.
- SUB:
  - 5000 − 1234 → 3766.
  - 1234 − 2345 → 0xFFFFFBA9.
  - −4000 − (−2000) → 0xFFFFF830.
  - −4000 − 1245 → 0xFFFFEB83.
- Shifts, A = 0xF0F0A4A4, B = 5:
  - SLL → 0x1E149480.
  - SRL → 0x07878525.
  - SRA → 0xFF878525.
- Compares:
  - SLT: (100, 5000) → 1; (−5000, −5001) → 0; (−1234, −1234) → 0.
  - SLTU: (1234, 4321) → 1; (−1234, −1000) → 1.
- Logic and pass, A = 0x1234F0F0, B = 0xFF001222:
  - XOR → 0xED34E2D2.
  - OR → 0xFF34F2F2.
  - AND → 0x12001020.
  - PASSB → 0xFF001222.
  - PASSA → 0x1234F0F0.
  - Reserved code 1010 → 0, `Zero` = 1.
- Reset and valid:
  - Assert `rst_n` = 0 mid-stream → `DataOut` = 0, `out_valid` = 0 immediately, without waiting for a clock edge.
  - Deassert `in_valid` → `DataOut` holds, `out_valid` = 0 after one edge.
